// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges a single-entry ALU holding buffer and a 2-entry load
// FIFO onto the register file write port, with a starvation guard for the ALU entry.
module wb_arbiter #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int ZR_DISCARD   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic [1:0]      mem_size,
  input  logic            mem_signed,
  output logic            RegWrite,
  output logic [4:0]      Write_register,
  output logic [XLEN-1:0] Write_d,
  output logic [31:0]     pending
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] d,
                                               input logic [1:0] sz,
                                               input logic sgn);
    logic [XLEN-1:0] r;
    case (sz)
      2'd0:    r = {{(XLEN-8){sgn & d[7]}}, d[7:0]};
      2'd1:    r = {{(XLEN-16){sgn & d[15]}}, d[15:0]};
      2'd2:    r = {{(XLEN-32){sgn & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  logic            alu_full_q, alu_full_d;
  logic [4:0]      alu_rd_q, alu_rd_d;
  logic [XLEN-1:0] alu_data_q, alu_data_d;
  logic [4:0]      fifo_rd_q [2];
  logic [4:0]      fifo_rd_d [2];
  logic [XLEN-1:0] fifo_data_q [2];
  logic [XLEN-1:0] fifo_data_d [2];
  logic            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [3:0]      starve_q, starve_d;
  logic            regwrite_q, regwrite_d;
  logic [4:0]      wreg_q, wreg_d;
  logic [XLEN-1:0] wd_q, wd_d;

  logic            sel_mem, sel_alu, sel, alu_push, mem_push;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;

  assign alu_ready      = !alu_full_q;
  assign mem_ready      = (cnt_q < 2'd2);
  assign RegWrite       = regwrite_q;
  assign Write_register = wreg_q;
  assign Write_d        = wd_q;

  // Arbitration looks only at registered state; flush suppresses any selection.
  always_comb begin
    sel_mem  = !flush && (cnt_q != 2'd0) && (!alu_full_q || (starve_q < LIMIT));
    sel_alu  = !flush && !sel_mem && alu_full_q;
    sel      = sel_mem || sel_alu;
    sel_rd   = sel_mem ? fifo_rd_q[rd_ptr_q]   : alu_rd_q;
    sel_data = sel_mem ? fifo_data_q[rd_ptr_q] : alu_data_q;
    alu_push = alu_valid && alu_ready && !flush;
    mem_push = mem_valid && mem_ready && !flush;
  end

  always_comb begin
    alu_full_d  = alu_full_q;
    alu_rd_d    = alu_rd_q;
    alu_data_d  = alu_data_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q ^ mem_push;
    rd_ptr_d    = rd_ptr_q ^ sel_mem;
    cnt_d       = cnt_q + 2'(mem_push) - 2'(sel_mem);
    starve_d    = starve_q;
    regwrite_d  = sel && !((ZR_DISCARD != 0) && (sel_rd == 5'd31));
    wreg_d      = wreg_q;
    wd_d        = wd_q;

    if (sel_alu) begin
      alu_full_d = 1'b0;
    end else if (alu_push) begin
      alu_full_d = 1'b1;
      alu_rd_d   = alu_rd;
      alu_data_d = alu_data;
    end

    if (mem_push) begin
      fifo_rd_d[wr_ptr_q]   = mem_rd;
      fifo_data_d[wr_ptr_q] = load_ext(mem_data, mem_size, mem_signed);
    end

    if (!alu_full_q || sel_alu) begin
      starve_d = 4'd0;
    end else if (sel_mem && (starve_q < LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end

    if (sel) begin
      wreg_d = sel_rd;
      wd_d   = sel_data;
    end

    if (flush) begin
      alu_full_d = 1'b0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      cnt_d      = 2'd0;
      starve_d   = 4'd0;
    end
  end

  // Hazard mask: held ALU entry, live FIFO entries, and the write on the port.
  always_comb begin
    pending = '0;
    if (alu_full_q) pending[alu_rd_q] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if ((cnt_q == 2'd2) || ((cnt_q == 2'd1) && (rd_ptr_q == 1'(i))))
        pending[fifo_rd_q[i]] = 1'b1;
    end
    if (regwrite_q) pending[wreg_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_full_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      starve_q   <= 4'd0;
      regwrite_q <= 1'b0;
      wreg_q     <= 5'd0;
      wd_q       <= '0;
    end else begin
      alu_full_q <= alu_full_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wd_q       <= wd_d;
    end
  end

  // Payload storage is qualified by the control flops above, so it needs no reset.
  always_ff @(posedge clk) begin
    alu_rd_q    <= alu_rd_d;
    alu_data_q  <= alu_data_d;
    fifo_rd_q   <= fifo_rd_d;
    fifo_data_q <= fifo_data_d;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected writes are queued as stimulus is issued
// and retired by a monitor whenever RegWrite is seen.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_rd;
  logic [63:0] mem_data;
  logic [1:0]  mem_size;
  logic        mem_signed;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [63:0] Write_d;
  logic [31:0] pending;

  wb_arbiter #(.XLEN(64), .STARVE_LIMIT(4), .ZR_DISCARD(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_size(mem_size), .mem_signed(mem_signed),
    .RegWrite(RegWrite), .Write_register(Write_register), .Write_d(Write_d),
    .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_total = 0;
  int  n_pass  = 0;
  int  n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [63:0] d);
    wr_t e;
    e.rd = rd;
    e.d  = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_mem_ready(output bit saw_stall);
    int n = 0;
    saw_stall = 1'b0;
    while (!mem_ready && n < 50) begin
      saw_stall = 1'b1;
      tick();
      n++;
    end
    if (n == 50) check("mem_ready_timeout", 64'(mem_ready), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && RegWrite) begin
      check("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_rd", 64'(Write_register), 64'(e.rd));
        check("write_data", Write_d, e.d);
      end
    end
  end

  initial begin
    bit stall, saw_full;
    rst = 1'b1; flush = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0; mem_size = '0; mem_signed = 1'b0;
    tick(); tick();
    check("rst_regwrite", 64'(RegWrite), 64'd0);
    check("rst_wreg", 64'(Write_register), 64'd0);
    check("rst_wd", Write_d, 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_alu_ready", 64'(alu_ready), 64'd1);
    check("rst_mem_ready", 64'(mem_ready), 64'd1);
    rst = 1'b0;
    tick();

    // Single ALU result: accepted at edge 1, written after edge 2 for one cycle.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
    expect_wr(5'd5, 64'h1234);
    tick();
    alu_valid = 1'b0;
    check("alu1_pending_held", 64'(pending), 64'h20);
    check("alu1_ready_low", 64'(alu_ready), 64'd0);
    check("alu1_no_write_yet", 64'(RegWrite), 64'd0);
    tick();
    check("alu1_write", 64'(RegWrite), 64'd1);
    check("alu1_pending_write", 64'(pending), 64'h20);
    check("alu1_ready_back", 64'(alu_ready), 64'd1);
    tick();
    check("alu1_pulse_end", 64'(RegWrite), 64'd0);
    check("alu1_pending_clear", 64'(pending), 64'd0);

    // Load extension cases, back to back.
    mem_valid = 1'b1;
    mem_rd = 5'd3; mem_data = 64'h80; mem_size = 2'd0; mem_signed = 1'b1;
    expect_wr(5'd3, 64'hFFFF_FFFF_FFFF_FF80);
    wait_mem_ready(stall); tick();
    mem_rd = 5'd3; mem_data = 64'h80; mem_size = 2'd0; mem_signed = 1'b0;
    expect_wr(5'd3, 64'h80);
    wait_mem_ready(stall); tick();
    mem_rd = 5'd4; mem_data = 64'h0000_0000_8000_0001; mem_size = 2'd2; mem_signed = 1'b1;
    expect_wr(5'd4, 64'hFFFF_FFFF_8000_0001);
    wait_mem_ready(stall); tick();
    mem_rd = 5'd6; mem_data = 64'h1234_8000; mem_size = 2'd1; mem_signed = 1'b1;
    expect_wr(5'd6, 64'hFFFF_FFFF_FFFF_8000);
    wait_mem_ready(stall); tick();
    mem_rd = 5'd7; mem_data = 64'h8000_0000_0000_00F0; mem_size = 2'd3; mem_signed = 1'b1;
    expect_wr(5'd7, 64'h8000_0000_0000_00F0);
    wait_mem_ready(stall); tick();
    mem_valid = 1'b0;
    drain();

    // Contention: ALU rd=1 held while loads stream; 4 loads win, then ALU, then loads.
    for (int i = 0; i < 4; i++) expect_wr(5'(10 + i), 64'(256 + i));
    expect_wr(5'd1, 64'hA1);
    for (int i = 4; i < 8; i++) expect_wr(5'(10 + i), 64'(256 + i));
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'hA1;
    mem_valid = 1'b1; mem_size = 2'd3; mem_signed = 1'b0;
    mem_rd = 5'd10; mem_data = 64'd256;
    tick();
    alu_valid = 1'b0;
    saw_full = 1'b0;
    for (int i = 1; i < 8; i++) begin
      mem_rd = 5'(10 + i); mem_data = 64'(256 + i);
      wait_mem_ready(stall);
      if (stall) saw_full = 1'b1;
      tick();
    end
    mem_valid = 1'b0;
    check("contention_fifo_full_seen", 64'(saw_full), 64'd1);
    drain();
    tick();

    // XZR: rd=31 consumed without a write.
    alu_valid = 1'b1; alu_rd = 5'd31; alu_data = 64'hDEAD;
    tick();
    alu_valid = 1'b0;
    check("xzr_pending_set", 64'(pending), 64'h8000_0000);
    check("xzr_ready_low", 64'(alu_ready), 64'd0);
    tick();
    check("xzr_no_write", 64'(RegWrite), 64'd0);
    check("xzr_ready_back", 64'(alu_ready), 64'd1);
    check("xzr_pending_clear", 64'(pending), 64'd0);
    check("xzr_wreg_loaded", 64'(Write_register), 64'd31);
    check("xzr_wd_loaded", Write_d, 64'hDEAD);
    tick();

    // Flush with buffered ALU and load entries while a load write is on the port.
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 64'hA2;
    mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 64'h20; mem_size = 2'd3;
    expect_wr(5'd20, 64'h20);
    tick();
    alu_valid = 1'b0;
    mem_rd = 5'd21; mem_data = 64'h21;
    check("flush_setup_alu_full", 64'(alu_ready), 64'd0);
    tick();
    check("flush_inflight_write", 64'(RegWrite), 64'd1);
    check("flush_pending_before", 64'(pending), 64'h0030_0004);
    mem_rd = 5'd22; mem_data = 64'h22;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mem_valid = 1'b0;
    check("flush_no_write", 64'(RegWrite), 64'd0);
    check("flush_pending_zero", 64'(pending), 64'd0);
    check("flush_alu_ready", 64'(alu_ready), 64'd1);
    check("flush_mem_ready", 64'(mem_ready), 64'd1);
    repeat (5) tick();
    check("flush_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset between edges while a write is on the port.
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
    tick();
    alu_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd23; mem_data = 64'h23;
    tick();
    mem_valid = 1'b0;
    check("arst_write_active", 64'(RegWrite), 64'd1);
    check("arst_pending_before", 64'(pending), 64'h0080_0200);
    #1 rst = 1'b1;
    #1;
    check("arst_regwrite", 64'(RegWrite), 64'd0);
    check("arst_wreg", 64'(Write_register), 64'd0);
    check("arst_wd", Write_d, 64'd0);
    check("arst_pending", 64'(pending), 64'd0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("arst_no_stale_writes", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage that drives the single write port of the 32x64 register file (X0-X31).
- Accepts results from two producers:
  - the ALU/execute path: single-entry holding buffer;
  - the memory/load path: 2-entry FIFO, with byte/half/word/dword load extension.
- Arbitrates both producers onto one registered write per cycle, with a starvation guard.
- Exports a pending-destination bitmask for hazard detection in decode.

Parameters:
- XLEN, 64, data width of register file and results.
- STARVE_LIMIT, 4, consecutive cycles the ALU entry may lose arbitration before it is forced to win one cycle; range 1-15.
- ZR_DISCARD, 1, when 1, writes with rd==31 are consumed but never asserted on RegWrite (XZR semantics).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; drops all buffered, not-yet-written results.
- alu_valid  input  1  ALU result valid.
- alu_ready  output  1  ALU buffer can accept.
- alu_rd  input  5  ALU destination register.
- alu_data  input  XLEN  ALU result.
- mem_valid  input  1  load result valid.
- mem_ready  output  1  load FIFO can accept.
- mem_rd  input  5  load destination register.
- mem_data  input  XLEN  raw load data, right-aligned.
- mem_size  input  2  0=byte, 1=half, 2=word, 3=dword.
- mem_signed  input  1  1=sign-extend, 0=zero-extend.
- RegWrite  output  1  register file write enable.
- Write_register  output  5  register file write address.
- Write_d  output  XLEN  register file write data.
- pending  output  32  bit r set while any buffered or in-flight write targets Xr.

Behaviour:
- Reset (async, rst=1): RegWrite=0, Write_register=0, Write_d=0, ALU hold empty, FIFO empty (count=0), starvation counter=0. Consequently alu_ready=1, mem_ready=1, pending=0.
- Handshake: transfer occurs on a rising edge where valid&&ready.
  - alu_ready = !alu_hold_full.
  - mem_ready = (fifo_count<2).
  - Both readys are functions of registered state only; no combinational valid->ready path.
  - Producers hold data stable while valid&&!ready.
- Load extension is applied at FIFO write; the FIFO stores final data.
  - Byte: extend from bit 7. Half: extend from bit 15. Word: extend from bit 31.
  - Dword: data passes unchanged; mem_signed is ignored.
- Arbitration, evaluated each cycle on buffered state only:
  - If FIFO non-empty and (ALU hold empty or starve_cnt<STARVE_LIMIT): pop FIFO head.
  - Else if ALU hold full: pop ALU hold.
  - Else: no selection.
- Starvation counter:
  - Increments when the ALU hold is full and the FIFO wins; saturates at STARVE_LIMIT.
  - Clears when the ALU entry wins or the ALU hold is empty.
- Output register:
  - On each edge, RegWrite <= selected && !(ZR_DISCARD && sel_rd==31).
  - Write_register and Write_d load from the selected entry only when selected (including the discarded rd==31 case); otherwise they hold their last value.
  - RegWrite is a 1-cycle pulse per write.
- Latency: a result accepted at edge k with no contention appears on RegWrite/Write_* after edge k+1.
- Simultaneous accept and pop:
  - The FIFO may push and pop on the same edge; count is unchanged.
  - ALU hold may refill on the edge after it is popped, never on the same edge, because alu_ready reflects the pre-edge state.
- pending: OR of one-hot(rd) over the ALU hold (if full), valid FIFO entries, and the output register (if RegWrite=1). rd==31 is included even when ZR_DISCARD=1.
- flush=1 at an edge:
  - ALU hold and FIFO are emptied; starve_cnt=0.
  - Input transfers on that edge are dropped.
  - No new selection is made: RegWrite=0 on the next cycle.
  - A write already on RegWrite during the flush cycle completes normally.
- Reset mid-operation: immediate return to reset values; buffered entries are lost.
- Ordering: per-source order is preserved (FIFO in order). No ordering is guaranteed between the ALU and memory sources; producers must not issue same-rd results on both paths without a decode stall keyed on pending.

Test Plan:
- Reset release, single ALU result alu_rd=5, alu_data=0x1234 at edge 1 -> RegWrite=1, Write_register=5, Write_d=0x1234 after edge 2 for exactly one cycle; pending[5] high from edge 1 through end of write cycle.
- Load extension: mem_data=0x80, size=0, signed=1, rd=3 -> Write_d=0xFFFF_FFFF_FFFF_FF80. Same with signed=0 -> 0x80. size=2, data=0x0000_0000_8000_0001, signed=1 -> 0xFFFF_FFFF_8000_0001.
- Contention: hold the ALU entry (rd=1) while streaming back-to-back loads, STARVE_LIMIT=4 -> 4 load writes, then 1 ALU write to X1, then loads resume. mem_ready drops when FIFO count=2.
- XZR: alu_rd=31 with ZR_DISCARD=1 -> entry consumed, alu_ready re-asserts, RegWrite stays 0, pending[31] clears.
- Flush with FIFO holding 2 loads and ALU hold full -> next cycle RegWrite=0, pending=0, both readys=1; the write already in flight still asserts once.
- Async reset asserted mid-stream (between edges) -> RegWrite, Write_register, Write_d, pending go 0 immediately without a clock edge.
